// File: rtl/ariane_mem_ctrl_pkg.sv
// Shared types and constants for the memory-side responder.
package ariane_mem_ctrl_pkg;

  // Tohost detector states; only reset leaves HALTED.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  // Fill pattern returned by out-of-range reads, replicated per 32-bit lane.
  localparam logic [31:0] OobPattern = 32'hDEAD_BEEF;

  // Default memory map.
  localparam logic [63:0] DefaultBaseAddr   = 64'h8000_0000;
  localparam logic [63:0] DefaultTohostAddr = 64'h8000_1000;

endpackage

// File: rtl/ariane_mem_ctrl_sram.sv
// Single-port, byte-enabled word array with a registered read port.
// Storage is not reset; only the read register is.
module ariane_mem_ctrl_sram
  import ariane_mem_ctrl_pkg::*;
#(
  parameter int unsigned NumWords  = 65536,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned IdxW     = $clog2(NumWords),
  localparam int unsigned ByteW    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [IdxW-1:0]      addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [ByteW-1:0]     be_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] rdata_q;

  // Byte-masked write into the array.
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      for (int b = 0; b < int'(ByteW); b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Registered read; holds its value on cycles without a read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (req_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ariane_mem_ctrl.sv
// Memory-side responder: word SRAM with one-cycle reads, byte-masked writes,
// out-of-range detection, tohost halt detection and a preload port.
//
// Handshake: mem_gnt_o is combinational (mem_req_i & ~ld_en_i); a request is
// accepted on the rising edge where req and gnt are both high. Upstream never
// waits on grant, so an ungranted request is simply lost. Read data for a
// granted read is valid on mem_rdata_o for the whole following cycle and held
// until the next granted read.
module ariane_mem_ctrl
  import ariane_mem_ctrl_pkg::*;
#(
  parameter int unsigned NumWords  = 65536,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter logic [AddrWidth-1:0] BaseAddr   = AddrWidth'(DefaultBaseAddr),
  parameter logic [AddrWidth-1:0] TohostAddr = AddrWidth'(DefaultTohostAddr),
  localparam int unsigned IdxW  = $clog2(NumWords),
  localparam int unsigned ByteW = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mem_req_i,
  output logic                 mem_gnt_o,
  input  logic [AddrWidth-1:0] mem_addr_i,
  input  logic [DataWidth-1:0] mem_wdata_i,
  input  logic [ByteW-1:0]     mem_strb_i,
  input  logic                 mem_we_i,
  output logic [DataWidth-1:0] mem_rdata_o,
  input  logic                 ld_en_i,
  input  logic                 ld_valid_i,
  input  logic [IdxW-1:0]      ld_idx_i,
  input  logic [DataWidth-1:0] ld_data_i,
  output logic                 halt_o,
  output logic [DataWidth-1:0] tohost_val_o,
  output logic [15:0]          oob_cnt_o,
  output logic [31:0]          req_cnt_o,
  output state_e               dbg_state_o
);

  localparam int unsigned ByteShift = $clog2(ByteW);
  localparam logic [AddrWidth-1:0] AlignMask = ~(AddrWidth'(ByteW - 1));
  localparam logic [DataWidth-1:0] OobFill = {(DataWidth / 32){OobPattern}};

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] byte_off, word_off;
  logic                 in_range;
  logic                 gnt, rd_gnt, wr_gnt, halted;
  logic                 trigger;
  logic                 oob_event;
  logic                 oob_q;
  logic [DataWidth-1:0] strb_mask;
  logic [DataWidth-1:0] tohost_q;
  logic [15:0]          oob_cnt_q;
  logic [31:0]          req_cnt_q;

  logic                 sram_req, sram_we;
  logic [IdxW-1:0]      sram_addr;
  logic [DataWidth-1:0] sram_wdata, sram_rdata;
  logic [ByteW-1:0]     sram_be;

  // Index/range decode; the in-word byte offset is discarded by the shift.
  always_comb begin
    byte_off = mem_addr_i - BaseAddr;
    word_off = byte_off >> ByteShift;
    in_range = (mem_addr_i >= BaseAddr) && (word_off < AddrWidth'(NumWords));
  end

  assign gnt       = mem_req_i & ~ld_en_i;
  assign rd_gnt    = gnt & ~mem_we_i;
  assign wr_gnt    = gnt & mem_we_i;
  assign halted    = (state_q == HALTED);
  assign mem_gnt_o = gnt;

  // Writes while halted are silently dropped and are not counted as OOB.
  assign oob_event = gnt & ~in_range & ~(mem_we_i & halted);

  assign trigger = (state_q == RUN) && wr_gnt &&
                   ((mem_addr_i & AlignMask) == TohostAddr) &&
                   mem_strb_i[0] && mem_wdata_i[0];

  // Expand byte strobes into a bit mask for the tohost capture.
  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < int'(ByteW); b++) begin
      strb_mask[b*8 +: 8] = {8{mem_strb_i[b]}};
    end
  end

  // Core/preload mux onto the single SRAM port; preload has full-word enables.
  always_comb begin
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_be    = '0;
    if (ld_en_i) begin
      sram_req   = ld_valid_i;
      sram_we    = 1'b1;
      sram_addr  = ld_idx_i;
      sram_wdata = ld_data_i;
      sram_be    = '1;
    end else begin
      sram_req   = (rd_gnt & in_range) | (wr_gnt & in_range & ~halted);
      sram_we    = mem_we_i;
      sram_addr  = word_off[IdxW-1:0];
      sram_wdata = mem_wdata_i;
      sram_be    = mem_strb_i;
    end
  end

  ariane_mem_ctrl_sram #(
    .NumWords  (NumWords),
    .DataWidth (DataWidth)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (sram_req),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (sram_wdata),
    .be_i    (sram_be),
    .rdata_o (sram_rdata)
  );

  // Tohost FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Tohost FSM next state: RUN -> HALTED on trigger, HALTED is sticky.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (trigger) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Capture the masked tohost value on the triggering write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      tohost_q <= '0;
    else if (trigger) tohost_q <= mem_wdata_i & strb_mask;
  end

  // Remember whether the last granted read was out of range to pick the fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     oob_q <= 1'b0;
    else if (rd_gnt) oob_q <= ~in_range;
  end

  // Access counters: OOB saturates, granted-request count wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oob_cnt_q <= '0;
      req_cnt_q <= '0;
    end else begin
      if (oob_event && (oob_cnt_q != 16'hFFFF)) oob_cnt_q <= oob_cnt_q + 16'd1;
      if (gnt) req_cnt_q <= req_cnt_q + 32'd1;
    end
  end

  assign mem_rdata_o  = oob_q ? OobFill : sram_rdata;
  assign halt_o       = halted;
  assign tohost_val_o = tohost_q;
  assign oob_cnt_o    = oob_cnt_q;
  assign req_cnt_o    = req_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/ariane_mem_ctrl.md
# ariane_mem_ctrl

Memory-side responder for the core's simple memory request port: a single-port word SRAM model with a fixed one-cycle read latency, byte-masked writes, out-of-range detection, and a tohost halt detector for test termination. It connects directly to the core top's `mem_req_o` / `mem_addr_o` / `mem_wdata_o` / `mem_strb_o` / `mem_we_o` outputs and drives its `mem_gnt_i` / `mem_rdata_i`. A word-preload port lets the testbench load a program image before the core runs.

## Interface
- `NumWords`, default 65536: SRAM depth in `DataWidth` words; must be a power of two.
- `AddrWidth`, default 64: request address width.
- `DataWidth`, default 64: word width; 32 or 64.
- `BaseAddr`, default 64'h8000_0000: byte address of word 0.
- `TohostAddr`, default 64'h8000_1000: byte address of the tohost word; must be word-aligned.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `mem_req_i`, in, 1: request valid.
- `mem_gnt_o`, out, 1: request accepted.
- `mem_addr_i`, in, AddrWidth: byte address.
- `mem_wdata_i`, in, DataWidth: write data.
- `mem_strb_i`, in, DataWidth/8: byte enables.
- `mem_we_i`, in, 1: 1 = write, 0 = read.
- `mem_rdata_o`, out, DataWidth: read data.
- `ld_en_i`, in, 1: preload mode; blocks core access.
- `ld_valid_i`, in, 1: preload write strobe.
- `ld_idx_i`, in, $clog2(NumWords): preload word index.
- `ld_data_i`, in, DataWidth: preload word.
- `halt_o`, out, 1: tohost halt seen.
- `tohost_val_o`, out, DataWidth: captured tohost value.
- `oob_cnt_o`, out, 16: out-of-range accesses; saturating.
- `req_cnt_o`, out, 32: granted requests; wraps.

## Operation
- Word index: idx = (addr − BaseAddr) >> log2(DataWidth/8). An access is in range iff addr ≥ BaseAddr and idx < NumWords. The address offset within a word is ignored.
- Grant: `mem_gnt_o` = `mem_req_i` & ~`ld_en_i`, combinational. Upstream does not stall on grant; a request with no grant is lost, by design.
- Granted read:
  - In range: `mem_rdata_o` = mem[idx], registered, on the next cycle.
  - Out of range: returns {DataWidth/32{32'hDEAD_BEEF}} and increments `oob_cnt_o`.
- Granted write:
  - Only bytes with a strobe bit set are written.
  - Out of range: the write is dropped and `oob_cnt_o` increments.
  - `mem_rdata_o` holds its previous value.
- `mem_rdata_o` holds its last value on every cycle with no granted read.
- Tohost detection:
  - FSM states: RUN and HALTED; only reset leaves HALTED.
  - Trigger, in RUN: a granted write with the word-aligned address equal to TohostAddr, `mem_strb_i`[0] = 1, and `mem_wdata_i`[0] = 1.
  - On trigger: go to HALTED and capture `tohost_val_o` = `mem_wdata_i` masked bytewise by strobe. The triggering write also updates memory.
  - A tohost write with bit0 = 0 is an ordinary write.
  - In HALTED: all core writes are dropped and not counted as OOB. Reads are still served, and `req_cnt_o` still counts.
- Preload: while `ld_en_i` = 1, each `ld_valid_i` writes the full word mem[`ld_idx_i`]. No core grant is given. Counters, FSM and `mem_rdata_o` are unchanged. Preload writes are accepted in HALTED.
- Read-after-write: a granted write in cycle N followed by a read of the same word in cycle N+1 returns the new data.

## Timing
- Read latency: exactly 1 cycle from the granted request edge to valid `mem_rdata_o`.
- `halt_o` and `tohost_val_o` update on the clock edge that samples the triggering write, so they are visible in the cycle after the request.
- Counters update on the same edge as the access they count.
- `oob_cnt_o` saturates at 16'hFFFF. `req_cnt_o` wraps from 32'hFFFF_FFFF to 0.
- Reset values: `mem_rdata_o` 0, `halt_o` 0, `tohost_val_o` 0, `oob_cnt_o` 0, `req_cnt_o` 0, FSM in RUN.
- Memory contents are not reset.
- Reset asserted mid-operation clears all registers asynchronously. A request in flight returns no data: `mem_rdata_o` reads 0 after reset.

## Structure
- Package `ariane_mem_ctrl_pkg`:
  - state enum {RUN, HALTED};
  - the OOB fill pattern constant 32'hDEAD_BEEF;
  - default BaseAddr and TohostAddr constants.
- Sub-module `ariane_mem_ctrl_sram`: single-port, byte-enabled, registered-read array. It has no reset on the storage.
- The top level holds:
  - the index/range decode;
  - the core/preload mux;
  - the tohost FSM;
  - the counters;
  - the OOB read-data select, using a registered OOB flag.

## Test plan
- Preload: write idx 0 = 64'h1122_3344_5566_7788 with `ld_en_i` = 1. Deassert, then read 64'h8000_0000 → `mem_rdata_o` = 64'h1122_3344_5566_7788 one cycle later, and `req_cnt_o` = 1.
- Byte strobe: word 0 holds 0, write 64'hFFFF_FFFF_FFFF_FFFF with strobe 8'h0F, then read → 64'h0000_0000_FFFF_FFFF.
- OOB: read 64'h7FFF_FFF8 → 64'hDEAD_BEEF_DEAD_BEEF. Write to BaseAddr + NumWords·8 → dropped. `oob_cnt_o` = 2; an adjacent in-range word is unchanged.
- Tohost:
  - Write 64'h0 to TohostAddr → `halt_o` stays 0.
  - Then write 64'h2B with strobe 8'hFF → `halt_o` = 1 and `tohost_val_o` = 64'h2B the next cycle.
  - A later write to word 0 is dropped, and reading word 0 returns the old value.
- Preload blocking and reset: with `ld_en_i` = 1, `mem_req_i` = 1 → `mem_gnt_o` = 0 and `req_cnt_o` unchanged. Then assert `rst_ni` = 0 mid-read → all outputs 0 at once, and memory still holds the preloaded data after reset is released.
